// File: rtl/cipher_frame_sched.sv
// Frame scheduler: once per period builds a plaintext block from the sensor reading, waits out the
// encryptor latency, then hands the ciphertext to the UART sender with a busy handshake.
module cipher_frame_sched #(
  parameter int PERIOD_CYCLES = 100_000_000,
  parameter int ENC_LATENCY   = 3,
  parameter int BUSY_WAIT     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [19:0] temp_data,
  output logic [63:0] enc_in,
  input  logic [63:0] enc_out,
  input  logic        uart_tx_busy,
  output logic        uart_en,
  output logic [63:0] uart_din,
  output logic [31:0] disp_data,
  output logic [15:0] frame_cnt,
  output logic [7:0]  overrun_cnt
);

  localparam int PW = $clog2(PERIOD_CYCLES);
  localparam int LW = $clog2(ENC_LATENCY + 1);
  localparam int BW = $clog2(BUSY_WAIT + 1);
  localparam logic [PW-1:0] PMAX = PW'(PERIOD_CYCLES - 1);
  localparam logic [LW-1:0] LMAX = LW'(ENC_LATENCY - 1);
  localparam logic [BW-1:0] BMAX = BW'(BUSY_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_ENC, WAIT_TX, SEND, WAIT_RISE, WAIT_FALL, DONE
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pcnt;
  logic [LW-1:0] lcnt;
  logic [BW-1:0] bcnt;
  logic          tick;

  assign tick = en && (pcnt == PMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              pcnt <= '0;
    else if (!en)         pcnt <= '0;
    else if (pcnt == PMAX) pcnt <= '0;
    else                  pcnt <= pcnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    uart_en   = 1'b0;
    case (state)
      IDLE:      if (tick) state_nxt = WAIT_ENC;
      WAIT_ENC:  if (lcnt == LMAX) state_nxt = WAIT_TX;
      WAIT_TX:   if (!uart_tx_busy) state_nxt = SEND;
      SEND: begin
        uart_en   = 1'b1;
        state_nxt = WAIT_RISE;
      end
      // A sender that never raises busy is treated as having finished its byte train.
      WAIT_RISE: begin
        if (uart_tx_busy)      state_nxt = WAIT_FALL;
        else if (bcnt == BMAX) state_nxt = DONE;
      end
      WAIT_FALL: if (!uart_tx_busy) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcnt <= '0;
      bcnt <= '0;
    end else begin
      if (state == IDLE && tick)  lcnt <= '0;
      else if (state == WAIT_ENC) lcnt <= lcnt + 1'b1;
      if (state == SEND)                          bcnt <= '0;
      else if (state == WAIT_RISE && !uart_tx_busy) bcnt <= bcnt + 1'b1;
    end
  end

  // The pre-increment frame count doubles as a nonce so identical readings encrypt differently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_in      <= '0;
      uart_din    <= '0;
      disp_data   <= '0;
      frame_cnt   <= '0;
      overrun_cnt <= '0;
    end else begin
      if (state == IDLE && tick) enc_in <= {frame_cnt, 28'h0, temp_data};
      if (state == WAIT_ENC && lcnt == LMAX) begin
        uart_din  <= enc_out;
        disp_data <= enc_out[31:0];
      end
      if (state == DONE) frame_cnt <= frame_cnt + 1'b1;
      if (tick && state != IDLE && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cipher_frame_sched.sv
// Self-checking bench for cipher_frame_sched: XOR encryptor and busy-pulsing UART models,
// a frame table driven through a scoreboard, plus hand sequences for overrun and reset cases.
module tb_cipher_frame_sched;

  localparam int PERIOD = 100;
  localparam int LAT    = 3;
  localparam int BWAIT  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [19:0] temp_data;
  logic [63:0] enc_in;
  logic [63:0] enc_out;
  logic        uart_tx_busy;
  logic        uart_en;
  logic [63:0] uart_din;
  logic [31:0] disp_data;
  logic [15:0] frame_cnt;
  logic [7:0]  overrun_cnt;

  int vec_count  = 0;
  int miss_count = 0;

  always #5 clk = ~clk;

  cipher_frame_sched #(
    .PERIOD_CYCLES(PERIOD),
    .ENC_LATENCY  (LAT),
    .BUSY_WAIT    (BWAIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .temp_data   (temp_data),
    .enc_in      (enc_in),
    .enc_out     (enc_out),
    .uart_tx_busy(uart_tx_busy),
    .uart_en     (uart_en),
    .uart_din    (uart_din),
    .disp_data   (disp_data),
    .frame_cnt   (frame_cnt),
    .overrun_cnt (overrun_cnt)
  );

  // Encryptor: inverts the block; result becomes valid just before the third edge after enc_in changes.
  logic [63:0] enc_p1 = '0;
  logic [63:0] enc_p2 = '0;
  always @(posedge clk) begin
    enc_p1 <= ~enc_in;
    enc_p2 <= enc_p1;
  end
  assign enc_out = enc_p2;

  int   tx_len_cfg = 0;
  int   tx_cnt;
  logic force_busy;
  always @(posedge clk or posedge rst) begin
    if (rst)                             tx_cnt <= 0;
    else if (uart_en && tx_len_cfg != 0) tx_cnt <= tx_len_cfg;
    else if (tx_cnt != 0)                tx_cnt <= tx_cnt - 1;
  end
  assign uart_tx_busy = force_busy | (tx_cnt != 0);

  int   ref_pcnt;
  logic ref_tick;
  always @(posedge clk or posedge rst) begin
    if (rst)                       ref_pcnt <= 0;
    else if (!en)                  ref_pcnt <= 0;
    else if (ref_pcnt == PERIOD-1) ref_pcnt <= 0;
    else                           ref_pcnt <= ref_pcnt + 1;
  end
  assign ref_tick = en && (ref_pcnt == PERIOD-1);

  logic [63:0] sb_q[$];

  typedef struct {
    logic [19:0] temp;
    int          pre;
    int          tx;
    logic [15:0] nonce;
    logic [63:0] exp_cipher;
    int          exp_k;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    vec_count++;
    if (act !== req) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitTick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ref_tick && n < 3*PERIOD);
    if (!ref_tick) begin
      vec_count++;
      miss_count++;
      $display("[TB] FAIL tick_timeout: no tick within %0d cycles", n);
    end
  endtask

  task automatic applyStimulus(input logic [19:0] temp, input int pre, input int tx,
                               input logic [15:0] fc);
    temp_data  = temp;
    tx_len_cfg = tx;
    force_busy = 1'b0;
    waitTick();
    force_busy = (pre > 0);
    sb_q.push_back(~{fc, 28'h0, temp});
  endtask

  // Returns the number of cycles from the caller's cycle to the uart_en pulse.
  task automatic waitSend(input int pre, output int k);
    logic [63:0] exp_val;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      force_busy = (k < pre);
    end while (!uart_en && k < 400);
    if (!uart_en) begin
      vec_count++;
      miss_count++;
      $display("[TB] FAIL uart_en_timeout: no start pulse after %0d cycles", k);
      if (sb_q.size() != 0) exp_val = sb_q.pop_front();
    end else if (sb_q.size() == 0) begin
      vec_count++;
      miss_count++;
      $display("[TB] FAIL sb_empty: uart_en with uart_din %h but nothing expected", uart_din);
    end else begin
      exp_val = sb_q.pop_front();
      checkOutput("uart_din", uart_din, exp_val);
      checkOutput("disp_data", {32'h0, disp_data}, {32'h0, exp_val[31:0]});
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    int cnt;

    vecs[0].temp = 20'hABCDE; vecs[0].pre = 0;  vecs[0].tx = 10;
    vecs[1].temp = 20'h00000; vecs[1].pre = 40; vecs[1].tx = 20;
    vecs[2].temp = 20'hFFFFF; vecs[2].pre = 0;  vecs[2].tx = 0;
    vecs[3].temp = 20'h12345; vecs[3].pre = 10; vecs[3].tx = 5;
    vecs[4].temp = 20'h001A3; vecs[4].pre = 0;  vecs[4].tx = 30;
    vecs[5].temp = 20'h80001; vecs[5].pre = 3;  vecs[5].tx = 1;
    for (int i = 0; i < 6; i++) begin
      vecs[i].nonce      = 16'(i + 1);
      vecs[i].exp_cipher = ~{vecs[i].nonce, 28'h0, vecs[i].temp};
      vecs[i].exp_k      = (vecs[i].pre > 4) ? vecs[i].pre + 1 : LAT + 2;
    end

    rst = 1'b1; en = 1'b0; temp_data = '0; force_busy = 1'b0;
    stepCycles(3);
    checkOutput("rst_uart_en", {63'h0, uart_en}, 64'h0);
    checkOutput("rst_enc_in", enc_in, 64'h0);
    checkOutput("rst_uart_din", uart_din, 64'h0);
    checkOutput("rst_disp_data", {32'h0, disp_data}, 64'h0);
    checkOutput("rst_frame_cnt", {48'h0, frame_cnt}, 64'h0);
    checkOutput("rst_overrun_cnt", {56'h0, overrun_cnt}, 64'h0);
    rst = 1'b0;
    stepCycles(2);

    // First frame: minimum latency and a sender that never raises busy.
    en = 1'b1;
    applyStimulus(20'h001A3, 0, 0, 16'd0);
    checkOutput("enc_in_at_tick", enc_in, 64'h0);
    waitSend(0, k);
    checkOutput("latency_first", k, LAT + 2);
    checkOutput("enc_in_frame0", enc_in, 64'h0000_0000_0000_01A3);
    checkOutput("uart_din_frame0", uart_din, 64'hFFFF_FFFF_FFFF_FE5C);
    @(negedge clk);
    checkOutput("uart_en_width", {63'h0, uart_en}, 64'h0);
    stepCycles(16);
    checkOutput("frame_cnt_in_done", {48'h0, frame_cnt}, 64'h0);
    @(negedge clk);
    checkOutput("frame_cnt_no_rise", {48'h0, frame_cnt}, 64'h1);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].temp, vecs[i].pre, vecs[i].tx, vecs[i].nonce);
      waitSend(vecs[i].pre, k);
      checkOutput($sformatf("latency_v%0d", i), k, vecs[i].exp_k);
      @(negedge clk);
      checkOutput($sformatf("uart_en_width_v%0d", i), {63'h0, uart_en}, 64'h0);
      stepCycles(((vecs[i].tx == 0) ? 18 : vecs[i].tx + 3) - 1);
      checkOutput($sformatf("frame_cnt_v%0d", i), {48'h0, frame_cnt}, {48'h0, vecs[i].nonce + 16'd1});
      checkOutput($sformatf("uart_din_hold_v%0d", i), uart_din, vecs[i].exp_cipher);
      checkOutput($sformatf("overrun_v%0d", i), {56'h0, overrun_cnt}, 64'h0);
    end

    // Long byte train: ticks at +100 and +200 fall inside the frame and are dropped.
    applyStimulus(20'h55555, 0, 250, 16'd7);
    waitSend(0, k);
    stepCycles(96);
    checkOutput("overrun_first_drop", {56'h0, overrun_cnt}, 64'd1);
    stepCycles(100);
    checkOutput("overrun_second_drop", {56'h0, overrun_cnt}, 64'd2);
    stepCycles(57);
    checkOutput("frame_cnt_long", {48'h0, frame_cnt}, 64'd8);

    // Frame whose DONE cycle coincides with the next tick.
    applyStimulus(20'h0BEEF, 0, 93, 16'd8);
    waitSend(0, k);
    stepCycles(95);
    checkOutput("frame_cnt_at_done", {48'h0, frame_cnt}, 64'd8);
    @(negedge clk);
    checkOutput("overrun_done_tick", {56'h0, overrun_cnt}, 64'd3);
    checkOutput("frame_cnt_after_done", {48'h0, frame_cnt}, 64'd9);
    checkOutput("enc_in_not_restarted", enc_in, {16'd8, 28'h0, 20'h0BEEF});
    applyStimulus(20'h0CAFE, 0, 5, 16'd9);
    waitSend(0, k);
    checkOutput("latency_after_drop", k, LAT + 2);
    stepCycles(8);
    checkOutput("frame_cnt_after_drop", {48'h0, frame_cnt}, 64'd10);

    // Stall in WAIT_TX long enough to saturate the overrun counter.
    applyStimulus(20'h00777, 0, 5, 16'd10);
    force_busy = 1'b1;
    for (int j = 1; j <= 300; j++) begin
      waitTick();
      if (j == 100) checkOutput("overrun_mid", {56'h0, overrun_cnt}, 64'd102);
    end
    @(negedge clk);
    checkOutput("overrun_saturated", {56'h0, overrun_cnt}, 64'hFF);
    checkOutput("uart_en_stalled", {63'h0, uart_en}, 64'h0);
    waitSend(0, k);
    checkOutput("latency_release", k, 2);
    stepCycles(8);
    checkOutput("frame_cnt_release", {48'h0, frame_cnt}, 64'd11);

    // Reset in WAIT_ENC, then a disabled period with no ticks.
    applyStimulus(20'h0ABCD, 0, 5, 16'd11);
    stepCycles(2);
    rst = 1'b1;
    #1;
    checkOutput("midrst_uart_en", {63'h0, uart_en}, 64'h0);
    checkOutput("midrst_enc_in", enc_in, 64'h0);
    checkOutput("midrst_uart_din", uart_din, 64'h0);
    checkOutput("midrst_disp_data", {32'h0, disp_data}, 64'h0);
    checkOutput("midrst_frame_cnt", {48'h0, frame_cnt}, 64'h0);
    checkOutput("midrst_overrun_cnt", {56'h0, overrun_cnt}, 64'h0);
    en = 1'b0;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int j = 0; j < 500; j++) begin
      @(negedge clk);
      if (uart_en) cnt++;
    end
    checkOutput("uart_en_while_disabled", cnt, 0);
    checkOutput("enc_in_while_disabled", enc_in, 64'h0);

    // en dropped right after the tick: the frame still completes.
    en = 1'b1;
    applyStimulus(20'h0F00D, 0, 0, 16'd0);
    @(negedge clk);
    en = 1'b0;
    checkOutput("enc_in_after_reset", enc_in, {16'd0, 28'h0, 20'h0F00D});
    waitSend(0, k);
    checkOutput("latency_en_low", k, LAT + 1);
    @(negedge clk);
    stepCycles(17);
    checkOutput("frame_cnt_en_low", {48'h0, frame_cnt}, 64'd1);
    stepCycles(200);
    checkOutput("frame_cnt_idle_disabled", {48'h0, frame_cnt}, 64'd1);
    checkOutput("overrun_after_reset", {56'h0, overrun_cnt}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
